// File: rtl/axi_mem_if_pkg.sv
// Shared types and constants for the AXI memory interface blocks.
package axi_mem_if_pkg;

  // Requester index on the shared SRAM port.
  typedef enum logic {
    PORT_RD = 1'b0,
    PORT_WR = 1'b1
  } port_e;

  // AXI response codes.
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Default memory geometry of the interface.
  localparam int unsigned MemAddrWidth = 13;
  localparam int unsigned DataWidth    = 64;
  localparam int unsigned NumBytes     = DataWidth / 8;

  // One full SRAM request as seen on the memory port.
  typedef struct packed {
    logic                    cen;
    logic                    wen;
    logic [MemAddrWidth-1:0] a;
    logic [DataWidth-1:0]    d;
    logic [NumBytes-1:0]     be;
  } mem_req_t;

endpackage

// File: rtl/axi_mem_streak_arb.sv
// Two-input arbiter that favours the last winner, bounded by a streak limit.
module axi_mem_streak_arb
  import axi_mem_if_pkg::*;
#(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rd_valid_i,
  input  logic wr_valid_i,
  output logic rd_grant_o,
  output logic wr_grant_o
);

  localparam int unsigned StreakW = $clog2(MAX_STREAK + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_STREAK);

  port_e               last_q, last_d, winner;
  logic [StreakW-1:0]  streak_q, streak_d;
  logic                any_grant;

  // Same-cycle grant: sticky to the last winner until its streak is used up.
  always_comb begin
    winner    = PORT_RD;
    any_grant = ~rst & (rd_valid_i | wr_valid_i);
    if (rd_valid_i && wr_valid_i) begin
      winner = (streak_q < StreakMax) ? last_q : port_e'(~last_q);
    end else if (wr_valid_i) begin
      winner = PORT_WR;
    end
    rd_grant_o = any_grant & (winner == PORT_RD);
    wr_grant_o = any_grant & (winner == PORT_WR);
  end

  // Streak bookkeeping; an idle cycle clears the streak but keeps the last winner.
  always_comb begin
    last_d   = last_q;
    streak_d = '0;
    if (any_grant) begin
      if (winner == last_q) begin
        streak_d = (streak_q == StreakMax) ? streak_q : streak_q + 1'b1;
      end else begin
        last_d   = winner;
        streak_d = StreakW'(1);
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q   <= PORT_RD;
      streak_q <= '0;
    end else begin
      last_q   <= last_d;
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/axi_mem_port_arbiter.sv
// Shares one single-port SRAM between the AXI read and write controllers.
module axi_mem_port_arbiter
  import axi_mem_if_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned NUMBYTES       = DATA_WIDTH / 8,
  parameter int unsigned MAX_STREAK     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      RD_valid_i,
  output logic                      RD_grant_o,
  input  logic                      RD_CEN_i,
  input  logic                      RD_WEN_i,
  input  logic [MEM_ADDR_WIDTH-1:0] RD_A_i,
  input  logic [DATA_WIDTH-1:0]     RD_D_i,
  input  logic [NUMBYTES-1:0]       RD_BE_i,
  output logic [DATA_WIDTH-1:0]     RD_Q_o,
  output logic                      RD_rvalid_o,
  input  logic                      WR_valid_i,
  output logic                      WR_grant_o,
  input  logic                      WR_CEN_i,
  input  logic                      WR_WEN_i,
  input  logic [MEM_ADDR_WIDTH-1:0] WR_A_i,
  input  logic [DATA_WIDTH-1:0]     WR_D_i,
  input  logic [NUMBYTES-1:0]       WR_BE_i,
  output logic [DATA_WIDTH-1:0]     WR_Q_o,
  output logic                      WR_rvalid_o,
  output logic                      MEM_CEN_o,
  output logic                      MEM_WEN_o,
  output logic [MEM_ADDR_WIDTH-1:0] MEM_A_o,
  output logic [DATA_WIDTH-1:0]     MEM_D_o,
  output logic [NUMBYTES-1:0]       MEM_BE_o,
  input  logic [DATA_WIDTH-1:0]     MEM_Q_i
);

  // Same shape as mem_req_t, sized by this instance's parameters.
  typedef struct packed {
    logic                      cen;
    logic                      wen;
    logic [MEM_ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0]     d;
    logic [NUMBYTES-1:0]       be;
  } port_req_t;

  port_req_t rd_req, wr_req, mem_req;
  logic      rd_grant, wr_grant;
  logic      q_valid_q, q_valid_d;
  port_e     q_owner_q, q_owner_d;

  assign rd_req = '{cen: RD_CEN_i, wen: RD_WEN_i, a: RD_A_i, d: RD_D_i, be: RD_BE_i};
  assign wr_req = '{cen: WR_CEN_i, wen: WR_WEN_i, a: WR_A_i, d: WR_D_i, be: WR_BE_i};

  axi_mem_streak_arb #(
    .MAX_STREAK (MAX_STREAK)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .rd_valid_i (RD_valid_i),
    .wr_valid_i (WR_valid_i),
    .rd_grant_o (rd_grant),
    .wr_grant_o (wr_grant)
  );

  assign RD_grant_o = rd_grant;
  assign WR_grant_o = wr_grant;

  // Memory port mux; idle port is deselected with zeroed payload.
  always_comb begin
    mem_req     = '0;
    mem_req.cen = 1'b1;
    mem_req.wen = 1'b1;
    if (rd_grant) begin
      mem_req = rd_req;
    end else if (wr_grant) begin
      mem_req = wr_req;
    end
    q_valid_d = (rd_grant | wr_grant) & ~mem_req.cen & mem_req.wen;
    q_owner_d = wr_grant ? PORT_WR : PORT_RD;
  end

  assign MEM_CEN_o = mem_req.cen;
  assign MEM_WEN_o = mem_req.wen;
  assign MEM_A_o   = mem_req.a;
  assign MEM_D_o   = mem_req.d;
  assign MEM_BE_o  = mem_req.be;

  // Tag of the read issued last cycle, matching the SRAM's one-cycle latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid_q <= 1'b0;
      q_owner_q <= PORT_RD;
    end else begin
      q_valid_q <= q_valid_d;
      q_owner_q <= q_owner_d;
    end
  end

  assign RD_Q_o      = MEM_Q_i;
  assign WR_Q_o      = MEM_Q_i;
  assign RD_rvalid_o = ~rst & q_valid_q & (q_owner_q == PORT_RD);
  assign WR_rvalid_o = ~rst & q_valid_q & (q_owner_q == PORT_WR);

`ifndef SYNTHESIS
  // A waiting requester must hold valid and its request until granted.
  rd_hold_a : assert property (@(posedge clk) disable iff (rst)
    (RD_valid_i && !RD_grant_o) |=>
      (RD_valid_i && $stable({RD_CEN_i, RD_WEN_i, RD_A_i, RD_D_i, RD_BE_i})));
  wr_hold_a : assert property (@(posedge clk) disable iff (rst)
    (WR_valid_i && !WR_grant_o) |=>
      (WR_valid_i && $stable({WR_CEN_i, WR_WEN_i, WR_A_i, WR_D_i, WR_BE_i})));
`endif

endmodule

// File: tb/tb_axi_mem_port_arbiter.sv
module tb_axi_mem_port_arbiter;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 64;
  localparam int unsigned NB = DW / 8;
  localparam int MS = 4;
  localparam int IDLE = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Per-port request stimulus, index 0 = RD, 1 = WR.
  logic          v   [2];
  logic          cen [2];
  logic          wen [2];
  logic [AW-1:0] a   [2];
  logic [DW-1:0] d   [2];
  logic [NB-1:0] be  [2];
  logic [DW-1:0] mem_q;

  logic          rd_grant, wr_grant, rd_rvalid, wr_rvalid;
  logic [DW-1:0] rd_q, wr_q;
  logic          mem_cen, mem_wen;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic [NB-1:0] mem_be;

  axi_mem_port_arbiter #(
    .MEM_ADDR_WIDTH (AW),
    .DATA_WIDTH     (DW),
    .NUMBYTES       (NB),
    .MAX_STREAK     (MS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .RD_valid_i  (v[0]),
    .RD_grant_o  (rd_grant),
    .RD_CEN_i    (cen[0]),
    .RD_WEN_i    (wen[0]),
    .RD_A_i      (a[0]),
    .RD_D_i      (d[0]),
    .RD_BE_i     (be[0]),
    .RD_Q_o      (rd_q),
    .RD_rvalid_o (rd_rvalid),
    .WR_valid_i  (v[1]),
    .WR_grant_o  (wr_grant),
    .WR_CEN_i    (cen[1]),
    .WR_WEN_i    (wen[1]),
    .WR_A_i      (a[1]),
    .WR_D_i      (d[1]),
    .WR_BE_i     (be[1]),
    .WR_Q_o      (wr_q),
    .WR_rvalid_o (wr_rvalid),
    .MEM_CEN_o   (mem_cen),
    .MEM_WEN_o   (mem_wen),
    .MEM_A_o     (mem_a),
    .MEM_D_o     (mem_d),
    .MEM_BE_o    (mem_be),
    .MEM_Q_i     (mem_q)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: grant history since reset (0 RD, 1 WR, 2 idle).
  int   hist[$];
  bit   m_qv = 1'b0;
  int   m_qown = 0;
  int   last_w = IDLE;
  logic obs_rd, obs_wr;

  function automatic int model_winner(input logic rv, input logic wv);
    int last, run;
    if (!rv && !wv) return IDLE;
    if (rv && !wv) return 0;
    if (!rv) return 1;
    last = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != IDLE) begin
        last = hist[i];
        break;
      end
    end
    run = 0;
    for (int i = hist.size() - 1; i >= 0 && run < MS; i--) begin
      if (hist[i] == last) run++;
      else break;
    end
    return (run < MS) ? last : 1 - last;
  endfunction

  // One clock: predict, check mid-cycle, then advance the model at the edge.
  task automatic cycle();
    int            w;
    logic          ecen, ewen;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [NB-1:0] ebe;
    mem_q = {$urandom, $urandom};
    w = rst ? IDLE : model_winner(v[0], v[1]);
    ecen = 1'b1; ewen = 1'b1; ea = '0; ed = '0; ebe = '0;
    if (w != IDLE) begin
      ecen = cen[w]; ewen = wen[w]; ea = a[w]; ed = d[w]; ebe = be[w];
    end
    @(negedge clk);
    obs_rd = rd_grant;
    obs_wr = wr_grant;
    check("rd_grant", 64'(rd_grant), 64'(w == 0));
    check("wr_grant", 64'(wr_grant), 64'(w == 1));
    check("mem_cen", 64'(mem_cen), 64'(ecen));
    check("mem_wen", 64'(mem_wen), 64'(ewen));
    check("mem_a", 64'(mem_a), 64'(ea));
    check("mem_d", mem_d, ed);
    check("mem_be", 64'(mem_be), 64'(ebe));
    check("rd_rvalid", 64'(rd_rvalid), 64'(!rst && m_qv && m_qown == 0));
    check("wr_rvalid", 64'(wr_rvalid), 64'(!rst && m_qv && m_qown == 1));
    check("rd_q", rd_q, mem_q);
    check("wr_q", wr_q, mem_q);
    @(posedge clk);
    if (rst) begin
      hist.delete();
      m_qv = 1'b0;
      m_qown = 0;
      last_w = IDLE;
    end else begin
      hist.push_back(w);
      m_qv = 1'b0;
      m_qown = 0;
      if (w != IDLE) begin
        m_qv = !cen[w] && wen[w];
        m_qown = w;
      end
      last_w = w;
    end
    #1;
  endtask

  task automatic set_req(input int p, input logic val, input logic c, input logic we,
                         input logic [AW-1:0] ad, input logic [DW-1:0] da,
                         input logic [NB-1:0] b);
    v[p] = val; cen[p] = c; wen[p] = we; a[p] = ad; d[p] = da; be[p] = b;
  endtask

  // Reset cycle also clears requests, as the controllers share this reset.
  task automatic do_reset();
    rst = 1'b1;
    set_req(0, 1'b0, 1'b1, 1'b1, '0, '0, '0);
    set_req(1, 1'b0, 1'b1, 1'b1, '0, '0, '0);
    cycle();
    rst = 1'b0;
  endtask

  int pat_b[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

  initial begin
    rst = 1'b1;
    set_req(0, 1'b0, 1'b1, 1'b1, '0, '0, '0);
    set_req(1, 1'b0, 1'b1, 1'b1, '0, '0, '0);
    mem_q = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Sole RD reader streaming three addresses.
    for (int i = 0; i < 3; i++) begin
      set_req(0, 1'b1, 1'b0, 1'b1, AW'(16 + i), '0, '1);
      cycle();
      check("sole_rd_grant", 64'(obs_rd), 64'(1));
    end
    set_req(0, 1'b0, 1'b1, 1'b1, '0, '0, '0);
    cycle();

    // Continuous contention from reset.
    do_reset();
    set_req(0, 1'b1, 1'b0, 1'b1, 13'h020, '0, '1);
    set_req(1, 1'b1, 1'b0, 1'b0, 13'h030, 64'h1234, '1);
    for (int i = 0; i < 9; i++) begin
      cycle();
      check("contend_wr", 64'(obs_wr), 64'(pat_b[i]));
      check("contend_rd", 64'(obs_rd), 64'(pat_b[i] == 0));
    end

    // RD twice, idle, then contention: RD keeps four grants.
    do_reset();
    set_req(0, 1'b1, 1'b0, 1'b1, 13'h040, '0, '1);
    cycle();
    cycle();
    set_req(0, 1'b0, 1'b1, 1'b1, '0, '0, '0);
    cycle();
    set_req(0, 1'b1, 1'b0, 1'b1, 13'h041, '0, '1);
    set_req(1, 1'b1, 1'b0, 1'b0, 13'h050, 64'h55, 8'h0F);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("idle_then_wr", 64'(obs_wr), 64'(i == 4));
    end

    // Sole write: no read return follows.
    do_reset();
    set_req(1, 1'b1, 1'b0, 1'b0, 13'h060, 64'hDEADBEEF, 8'hFF);
    cycle();
    set_req(1, 1'b0, 1'b1, 1'b1, '0, '0, '0);
    cycle();
    check("write_no_rvalid", 64'(wr_rvalid), 64'(0));

    // Reset pulse while WR owns the streak; RD wins afterwards.
    do_reset();
    set_req(0, 1'b1, 1'b0, 1'b1, 13'h070, '0, '1);
    set_req(1, 1'b1, 1'b0, 1'b0, 13'h080, 64'h99, '1);
    for (int i = 0; i < 6; i++) cycle();
    rst = 1'b1;
    cycle();
    check("rst_no_grant", 64'({obs_rd, obs_wr}), 64'(0));
    rst = 1'b0;
    cycle();
    check("post_rst_rd", 64'(obs_rd), 64'(1));

    // Request without a real access.
    do_reset();
    set_req(0, 1'b1, 1'b1, 1'b1, 13'h090, '0, '1);
    cycle();
    set_req(0, 1'b0, 1'b1, 1'b1, '0, '0, '0);
    cycle();
    check("cen_hi_no_rvalid", 64'(rd_rvalid), 64'(0));

    // Randomised traffic honouring the hold-until-granted contract.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!(v[p] && last_w != p)) begin
          set_req(p, $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 20, 1'($urandom),
                  AW'($urandom), {$urandom, $urandom}, NB'($urandom));
        end
      end
      rst = ($urandom_range(0, 99) < 2);
      cycle();
      rst = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
